// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and burst-length helper for the LCD frame reader.
package lcd_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 480;
    localparam int unsigned DEF_V_ACTIVE    = 272;
    localparam int unsigned DEF_BURST_LEN   = 64;
    localparam int unsigned DEF_FIFO_DEPTH  = 512;
    localparam int unsigned DEF_FILL_THRESH = 256;
    localparam int unsigned DEF_BANK_OFFSET = 32'h0002_0000;

    localparam int unsigned FRAME_WORDS = DEF_H_ACTIVE * DEF_V_ACTIVE;

    // Remaining-word counter and burst-length widths (130560 needs 17 bits).
    localparam int unsigned REM_W = 17;
    localparam int unsigned LEN_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_CHECK = 3'd2,
        ST_REQ   = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    function automatic logic [LEN_W-1:0] burst_len(input logic [REM_W-1:0] remaining,
                                                   input logic [LEN_W-1:0] max_len);
        return (remaining > REM_W'(max_len)) ? max_len : remaining[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/lcd_fs_detect.sv
// Frame-start detector: one-cycle pulse when the registered lcd_vs enters VS_POL.
module lcd_fs_detect #(
    parameter logic VS_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lcd_vs,
    output logic fs
);

    logic vs_q, vs_d;
    logic vs_prev_q, vs_prev_d;

    always_comb begin
        vs_d      = lcd_vs;
        vs_prev_d = vs_q;
    end

    // Reset to the inactive level so a held-inactive sync gives no spurious pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= ~VS_POL;
            vs_prev_q <= ~VS_POL;
        end else begin
            vs_q      <= vs_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign fs = (vs_q == VS_POL) && (vs_prev_q != VS_POL);

endmodule

// File: rtl/lcd_frame_reader.sv
// Read-side burst scheduler keeping the LCD line FIFO filled from SDRAM.
// Define FRAME_PINGPONG_EN to alternate the display between two frame banks.
module lcd_frame_reader
    import lcd_pkg::*;
#(
    parameter int unsigned       H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned       V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned       FILL_THRESH = DEF_FILL_THRESH,
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(DEF_BANK_OFFSET),
    parameter logic              VS_POL      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lcd_vs,
    input  logic              lcd_de,
    input  logic [9:0]        fifo_wrusedw,
    input  logic              fifo_empty,
    output logic              fifo_aclr,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [9:0]        rd_len,
    input  logic              rd_done,
    input  logic              wr_frame_done,
    output logic              underflow
);

    localparam logic [REM_W-1:0] FRAME_LEN = REM_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(BURST_LEN);
    localparam logic [9:0]       THRESH    = 10'(FILL_THRESH);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               underflow_q, underflow_d;
    logic               fs_pend_q, fs_pend_d;
    logic               fs;
    logic [ADDR_W-1:0]  flush_base;
    logic               unused_cfg;

    lcd_fs_detect #(
        .VS_POL (VS_POL)
    ) u_fs_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .lcd_vs (lcd_vs),
        .fs     (fs)
    );

`ifdef FRAME_PINGPONG_EN
    logic bank_q, bank_d;
    logic swap_q, swap_d;

    // A writer completion arriving during FLUSH is kept for the next frame.
    always_comb begin
        bank_d = bank_q;
        swap_d = swap_q | wr_frame_done;
        if (state_q == ST_FLUSH) begin
            bank_d = bank_q ^ swap_q;
            swap_d = wr_frame_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 1'b0;
            swap_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            swap_q <= swap_d;
        end
    end

    assign flush_base = bank_d ? (BASE_ADDR + BANK_OFFSET) : BASE_ADDR;
    assign unused_cfg = (FIFO_DEPTH == 0);
`else
    assign flush_base = BASE_ADDR;
    assign unused_cfg = wr_frame_done ^ (|BANK_OFFSET) ^ (FIFO_DEPTH == 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // rd_req/rd_ack: request stays high with rd_addr/rd_len stable until the
    // cycle rd_ack is seen, drops the next cycle; rd_done closes that one burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fs) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_CHECK;
            ST_CHECK: begin
                if (fs)                          state_d = ST_FLUSH;
                else if (remaining_q == '0)      state_d = ST_IDLE;
                else if (fifo_wrusedw < THRESH)  state_d = ST_REQ;
            end
            ST_REQ: begin
                if (rd_ack)  state_d = ST_WAIT;
                else if (fs) state_d = ST_FLUSH;
            end
            ST_WAIT: begin
                if (rd_done) state_d = (fs_pend_q || fs) ? ST_FLUSH : ST_CHECK;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // A frame start seen with a burst in flight is deferred until rd_done.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        fs_pend_d   = fs_pend_q;
        underflow_d = underflow_q | (lcd_de & fifo_empty);
        case (state_q)
            ST_FLUSH: begin
                rd_addr_d   = flush_base;
                remaining_d = FRAME_LEN;
                underflow_d = 1'b0;
                fs_pend_d   = 1'b0;
            end
            ST_REQ: begin
                if (rd_ack) fs_pend_d = fs;
            end
            ST_WAIT: begin
                if (rd_done) begin
                    if (!(fs_pend_q || fs)) begin
                        rd_addr_d   = rd_addr_q + ADDR_W'(rd_len);
                        remaining_d = remaining_q - REM_W'(rd_len);
                    end
                end else if (fs) begin
                    fs_pend_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q   <= BASE_ADDR;
            remaining_q <= '0;
            underflow_q <= 1'b0;
            fs_pend_q   <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            underflow_q <= underflow_d;
            fs_pend_q   <= fs_pend_d;
        end
    end

    always_comb begin
        fifo_aclr = (state_q == ST_FLUSH);
        rd_req    = (state_q == ST_REQ);
        rd_addr   = rd_addr_q;
        rd_len    = burst_len(remaining_q, MAX_LEN);
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Directed bench for lcd_frame_reader: default-size DUT plus a 100x1 frame DUT.
`timescale 1ns/1ps
module tb_lcd_frame_reader;

`ifdef FRAME_PINGPONG_EN
    localparam logic [23:0] EXP_BANK = 24'h020000;
`else
    localparam logic [23:0] EXP_BANK = 24'h000000;
`endif

    logic        clk;
    logic        rst_n;
    logic        lcd_vs;
    logic        lcd_de;
    logic [9:0]  fifo_wrusedw;
    logic        fifo_empty;
    logic        rd_ack;
    logic        rd_done;
    logic        wr_frame_done;
    logic        sel_small;

    logic        fifo_aclr_b, rd_req_b, underflow_b;
    logic [23:0] rd_addr_b;
    logic [9:0]  rd_len_b;
    logic        fifo_aclr_s, rd_req_s, underflow_s;
    logic [23:0] rd_addr_s;
    logic [9:0]  rd_len_s;

    logic        fifo_aclr_m, rd_req_m, underflow_m;
    logic [23:0] rd_addr_m;
    logic [9:0]  rd_len_m;

    int          n_tests;
    int          n_fail;
    logic [33:0] exp_q[$];

    assign fifo_aclr_m = sel_small ? fifo_aclr_s : fifo_aclr_b;
    assign rd_req_m    = sel_small ? rd_req_s    : rd_req_b;
    assign underflow_m = sel_small ? underflow_s : underflow_b;
    assign rd_addr_m   = sel_small ? rd_addr_s   : rd_addr_b;
    assign rd_len_m    = sel_small ? rd_len_s    : rd_len_b;

    lcd_frame_reader u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lcd_vs        (lcd_vs),
        .lcd_de        (lcd_de),
        .fifo_wrusedw  (fifo_wrusedw),
        .fifo_empty    (fifo_empty),
        .fifo_aclr     (fifo_aclr_b),
        .rd_req        (rd_req_b),
        .rd_ack        (rd_ack),
        .rd_addr       (rd_addr_b),
        .rd_len        (rd_len_b),
        .rd_done       (rd_done),
        .wr_frame_done (wr_frame_done),
        .underflow     (underflow_b)
    );

    lcd_frame_reader #(
        .H_ACTIVE (100),
        .V_ACTIVE (1)
    ) u_dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .lcd_vs        (lcd_vs),
        .lcd_de        (lcd_de),
        .fifo_wrusedw  (fifo_wrusedw),
        .fifo_empty    (fifo_empty),
        .fifo_aclr     (fifo_aclr_s),
        .rd_req        (rd_req_s),
        .rd_ack        (rd_ack),
        .rd_addr       (rd_addr_s),
        .rd_len        (rd_len_s),
        .rd_done       (rd_done),
        .wr_frame_done (wr_frame_done),
        .underflow     (underflow_s)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return rd_req_m;
            1:       return fifo_aclr_m;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_quiet(input int which, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (probe(which)) begin
                found = 1'b1;
                break;
            end
            if (i < budget) step();
        end
    endtask

    task automatic wait_for(input int which, input int budget, input string tag);
        bit found;
        wait_quiet(which, budget, found);
        check(tag, 64'(found), 64'd1);
    endtask

    // Driver tasks
    task automatic do_reset();
        rst_n         = 1'b0;
        lcd_vs        = 1'b1;
        lcd_de        = 1'b0;
        fifo_empty    = 1'b0;
        rd_ack        = 1'b0;
        rd_done       = 1'b0;
        wr_frame_done = 1'b0;
        fifo_wrusedw  = 10'd0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic frame_start();
        lcd_vs = 1'b1;
        step();
        step();
        lcd_vs = 1'b0;
        step();
    endtask

    // Controller model: accept the pending request, then report completion.
    task automatic serve(input int ack_dly, input int done_dly,
                         output logic [23:0] addr, output logic [9:0] len);
        addr = rd_addr_m;
        len  = rd_len_m;
        repeat (ack_dly) step();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        repeat (done_dly) step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        logic [9:0]  l;
        logic [23:0] last;
        bit          found;
        int          count;
        int          bad;
        int          seen;

        n_tests   = 0;
        n_fail    = 0;
        sel_small = 1'b0;

        // t1: reset values, frame start flush, first request
        do_reset();
        check("t1_rst_aclr", 64'(fifo_aclr_m), 64'd0);
        check("t1_rst_req", 64'(rd_req_m), 64'd0);
        check("t1_rst_addr", 64'(rd_addr_m), 64'd0);
        check("t1_rst_len", 64'(rd_len_m), 64'd0);
        check("t1_rst_uf", 64'(underflow_m), 64'd0);
        frame_start();
        wait_for(1, 5, "t1_aclr");
        step();
        check("t1_aclr_one_cycle", 64'(fifo_aclr_m), 64'd0);
        wait_for(0, 5, "t1_req");
        check("t1_addr", 64'(rd_addr_m), 64'd0);
        check("t1_len", 64'(rd_len_m), 64'd64);

        // t2: fill-threshold hold-off, slow ack, next address
        do_reset();
        fifo_wrusedw = 10'd300;
        frame_start();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) fifo_wrusedw = 10'd256;
            if (rd_req_m) seen++;
            step();
        end
        check("t2_hold_off", 64'(seen), 64'd0);
        fifo_wrusedw = 10'd255;
        wait_for(0, 5, "t2_req");
        check("t2_addr0", 64'(rd_addr_m), 64'd0);
        a   = rd_addr_m;
        bad = 0;
        repeat (3) begin
            step();
            if (!rd_req_m || rd_addr_m !== a || rd_len_m !== 10'd64) bad++;
        end
        check("t2_req_stable", 64'(bad), 64'd0);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check("t2_req_drop", 64'(rd_req_m), 64'd0);
        repeat (2) step();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        wait_for(0, 5, "t2_req2");
        check("t2_addr2", 64'(rd_addr_m), 64'h40);

        // t3: full frame with an always-hungry FIFO
        do_reset();
        frame_start();
        count = 0;
        bad   = 0;
        last  = '0;
        while (count < 2100) begin
            wait_quiet(0, 10, found);
            if (!found) break;
            serve(0, 0, a, l);
            if (a !== 24'(count * 64)) bad++;
            if (l !== 10'd64) bad++;
            last = a;
            count++;
        end
        check("t3_burst_count", 64'(count), 64'd2040);
        check("t3_last_addr", 64'(last), 64'h1FDC0);
        check("t3_addr_len_seq", 64'(bad), 64'd0);
        wait_quiet(0, 20, found);
        check("t3_idle_no_req", 64'(found), 64'd0);

        // t5: frame start during WAIT is deferred until rd_done
        do_reset();
        frame_start();
        wait_for(0, 6, "t5_req0");
        serve(0, 1, a, l);
        wait_for(0, 5, "t5_req1");
        check("t5_addr1", 64'(rd_addr_m), 64'h40);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        frame_start();
        bad = 0;
        repeat (6) begin
            if (fifo_aclr_m || rd_req_m) bad++;
            step();
        end
        check("t5_no_flush_in_wait", 64'(bad), 64'd0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        wait_for(1, 3, "t5_aclr_after_done");
        wait_for(0, 5, "t5_req_restart");
        check("t5_addr_restart", 64'(rd_addr_m), 64'd0);

        // t5b: frame start in REQ without ack drops the request and flushes
        frame_start();
        wait_for(1, 3, "t5b_aclr");
        check("t5b_req_dropped", 64'(rd_req_m), 64'd0);
        wait_for(0, 5, "t5b_req");
        check("t5b_addr", 64'(rd_addr_m), 64'd0);
        check("t5b_len", 64'(rd_len_m), 64'd64);

        // t5c: asynchronous reset mid-request
        rst_n = 1'b0;
        #1;
        check("t5c_async_req", 64'(rd_req_m), 64'd0);
        check("t5c_async_len", 64'(rd_len_m), 64'd0);

        // t6: sticky underflow, cleared by the next frame start
        do_reset();
        fifo_wrusedw = 10'd300;
        frame_start();
        wait_for(1, 5, "t6_aclr0");
        step();
        lcd_de     = 1'b1;
        fifo_empty = 1'b1;
        check("t6_uf_before", 64'(underflow_m), 64'd0);
        step();
        lcd_de     = 1'b0;
        fifo_empty = 1'b0;
        check("t6_uf_set", 64'(underflow_m), 64'd1);
        repeat (5) step();
        check("t6_uf_held", 64'(underflow_m), 64'd1);
        frame_start();
        wait_for(1, 3, "t6_aclr1");
        check("t6_uf_during_flush", 64'(underflow_m), 64'd1);
        step();
        check("t6_uf_cleared", 64'(underflow_m), 64'd0);

        // t7: display bank selection after a writer frame completion
        do_reset();
        wr_frame_done = 1'b1;
        step();
        wr_frame_done = 1'b0;
        frame_start();
        wait_for(0, 6, "t7_req1");
        check("t7_addr1", 64'(rd_addr_m), 64'(EXP_BANK));
        frame_start();
        wait_for(1, 3, "t7_aclr2");
        wait_for(0, 5, "t7_req2");
        check("t7_addr2", 64'(rd_addr_m), 64'(EXP_BANK));

        // t4: 100x1 frame -> bursts of 64 then 36
        sel_small = 1'b1;
        do_reset();
        exp_q.push_back({24'd0, 10'd64});
        exp_q.push_back({24'd64, 10'd36});
        frame_start();
        while (exp_q.size() > 0) begin
            wait_quiet(0, 10, found);
            check("t4_req", 64'(found), 64'd1);
            if (!found) break;
            serve(0, 1, a, l);
            check("t4_burst", 64'({a, l}), 64'(exp_q.pop_front()));
        end
        wait_quiet(0, 20, found);
        check("t4_idle_no_req", 64'(found), 64'd0);
        sel_small = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
